// File: rtl/seg_arb_pkg.sv
// Shared types and constants for the segment-display arbiter.
package seg_arb_pkg;

    localparam int DIGIT_W      = 4;
    localparam int REQ_W        = 16;
    localparam int NREQ_DEFAULT = 3;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_OWN  = 1'b1
    } state_t;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/seg_arbiter_rr_pick.sv
// Combinational round-robin picker: scans from last+1 (mod NREQ) and returns the first requester found.
module rr_pick
    import seg_arb_pkg::*;
#(
    parameter int NREQ = NREQ_DEFAULT
) (
    input  logic [NREQ-1:0] req,
    input  logic [1:0]      last,
    output logic [1:0]      pick,
    output logic            valid
);

    // Scan from farthest to nearest so the nearest hit after 'last' overwrites the others.
    always_comb begin
        pick  = 2'd0;
        valid = 1'b0;
        for (int k = NREQ; k >= 1; k--) begin
            int  idx;
            logic hit;
            idx   = (int'(last) + k) % NREQ;
            hit   = |(req & (NREQ'(1) << idx));
            pick  = hit ? 2'(idx) : pick;
            valid = valid | hit;
        end
    end

endmodule

// File: rtl/seg_arbiter.sv
// Round-robin owner arbiter for a 4-digit BCD display with minimum dwell time.
// Optional owner preemption after MAX_HOLD cycles is enabled by defining SEG_ARB_TIMEOUT_EN.
module seg_arbiter
    import seg_arb_pkg::*;
#(
    parameter int NREQ      = NREQ_DEFAULT,
    parameter int MIN_DWELL = 50000,
    parameter int MAX_HOLD  = 2000000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [REQ_W*NREQ-1:0] data,
    output logic [NREQ-1:0]       grant,
    output logic [DIGIT_W-1:0]    bcd0,
    output logic [DIGIT_W-1:0]    bcd1,
    output logic [DIGIT_W-1:0]    bcd2,
    output logic [DIGIT_W-1:0]    bcd3,
    output logic [1:0]            owner,
    output logic                  busy
);

    localparam int DWELL_MAX = max2(MIN_DWELL, MAX_HOLD);
    localparam int DWELL_W   = $clog2(DWELL_MAX + 1);
    localparam logic [DWELL_W-1:0] DWELL_SAT = DWELL_W'(DWELL_MAX);
    localparam logic [DWELL_W-1:0] MIN_REL   = DWELL_W'(MIN_DWELL - 1);

    state_t             state_q, state_d;
    logic [NREQ-1:0]    grant_q, grant_d;
    logic [1:0]         owner_q, owner_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic [REQ_W-1:0]   bcd_q, bcd_d;

    logic [1:0]       pick_s;
    logic             pick_valid_s;
    logic [NREQ-1:0]  own_mask_s;
    logic             own_req_s;
    logic             preempt_s;
    logic             release_s;
    logic [REQ_W-1:0] owner_data_s;
    logic [REQ_W-1:0] pick_data_s;

    rr_pick #(.NREQ(NREQ)) u_rr_pick (
        .req   (req),
        .last  (owner_q),
        .pick  (pick_s),
        .valid (pick_valid_s)
    );

    assign own_mask_s   = NREQ'(1) << owner_q;
    assign own_req_s    = |(req & own_mask_s);
    assign owner_data_s = data[REQ_W*int'(owner_q) +: REQ_W];
    assign pick_data_s  = data[REQ_W*int'(pick_s) +: REQ_W];

`ifdef SEG_ARB_TIMEOUT_EN
    localparam logic [DWELL_W-1:0] MAX_REL = DWELL_W'(MAX_HOLD - 1);
    logic rival_s;
    assign rival_s   = |(req & ~own_mask_s);
    assign preempt_s = rival_s && (dwell_q >= MAX_REL);
`else
    assign preempt_s = 1'b0;
`endif

    assign release_s = (!own_req_s && (dwell_q >= MIN_REL)) || preempt_s;

    // Next-state: arbitrate in IDLE, track dwell and refresh digits in OWN.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        owner_d = owner_q;
        dwell_d = dwell_q;
        bcd_d   = bcd_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_valid_s) begin
                    state_d = ST_OWN;
                    grant_d = NREQ'(1) << pick_s;
                    owner_d = pick_s;
                    dwell_d = '0;
                    bcd_d   = pick_data_s;
                end else begin
                    grant_d = '0;
                end
            end
            ST_OWN: begin
                dwell_d = (dwell_q == DWELL_SAT) ? dwell_q : dwell_q + DWELL_W'(1);
                if (own_req_s) begin
                    bcd_d = owner_data_s;
                end else begin
                    bcd_d = bcd_q;
                end
                if (release_s) begin
                    state_d = ST_IDLE;
                    grant_d = '0;
                end else begin
                    grant_d = grant_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
    end

    // State and output registers; reset hands the first arbitration to requester 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            owner_q <= 2'(NREQ - 1);
            dwell_q <= '0;
            bcd_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            owner_q <= owner_d;
            dwell_q <= dwell_d;
            bcd_q   <= bcd_d;
        end
    end

    assign grant = grant_q;
    assign owner = owner_q;
    assign busy  = (state_q == ST_OWN);
    assign bcd0  = bcd_q[3:0];
    assign bcd1  = bcd_q[7:4];
    assign bcd2  = bcd_q[11:8];
    assign bcd3  = bcd_q[15:12];

endmodule

// File: tb/tb_seg_arbiter.sv
// Self-checking bench for seg_arbiter: cycle model plus directed scenarios with literal expectations.
module tb_seg_arbiter;

    localparam int NREQ      = 3;
    localparam int MIN_DWELL = 4;
    localparam int MAX_HOLD  = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  req;
    logic [47:0] data;
    logic [2:0]  grant;
    logic [3:0]  bcd0, bcd1, bcd2, bcd3;
    logic [1:0]  owner;
    logic        busy;

    int n_chk  = 0;
    int n_fail = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    seg_arbiter #(.NREQ(NREQ), .MIN_DWELL(MIN_DWELL), .MAX_HOLD(MAX_HOLD)) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .data  (data),
        .grant (grant),
        .bcd0  (bcd0),
        .bcd1  (bcd1),
        .bcd2  (bcd2),
        .bcd3  (bcd3),
        .owner (owner),
        .busy  (busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model: who owns the display, for how many cycles, and what digits are shown.
    int          m_owner = NREQ - 1;
    bit          m_busy  = 1'b0;
    int          m_held  = 0;
    logic [15:0] m_bcd   = 16'h0000;

    always @(posedge clk) begin
        int          o;
        bit          b;
        int          h;
        logic [15:0] bc;
        bit          rel;
        o = m_owner; b = m_busy; h = m_held; bc = m_bcd;
        if (rst) begin
            o = NREQ - 1; b = 1'b0; h = 0; bc = 16'h0000;
        end else if (!b) begin
            for (int k = 1; k <= NREQ; k++) begin
                if (!b && req[(m_owner + k) % NREQ]) begin
                    o = (m_owner + k) % NREQ;
                    b = 1'b1;
                end
            end
            if (b) begin
                h  = 0;
                bc = data[16*o +: 16];
            end
        end else begin
            rel = !req[o] && (h >= MIN_DWELL - 1);
`ifdef SEG_ARB_TIMEOUT_EN
            if (h >= MAX_HOLD - 1 && (req & ~(3'b001 << o)) != 3'b000) rel = 1'b1;
`endif
            if (req[o]) bc = data[16*o +: 16];
            h = h + 1;
            if (rel) b = 1'b0;
        end
        m_owner <= o; m_busy <= b; m_held <= h; m_bcd <= bc;
    end

    // Compare every output against the model on each falling edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("model_grant", {29'd0, grant}, m_busy ? (32'd1 << m_owner) : 32'd0);
            chk("model_busy",  {31'd0, busy},  {31'd0, m_busy});
            chk("model_owner", {30'd0, owner}, m_owner);
            chk("model_bcd",   {16'd0, bcd3, bcd2, bcd1, bcd0}, {16'd0, m_bcd});
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic wait_idle(input int limit);
        int i = 0;
        while (grant !== 3'b000 && i < limit) begin
            cyc(1);
            i++;
        end
        chk("wait_idle", {29'd0, grant}, 32'd0);
    endtask

    logic [2:0] exp_seq [4] = '{3'b001, 3'b010, 3'b100, 3'b001};
    logic [2:0] seq [$];
    int         gaps [$];

    initial begin
        int cnt;
        int held;
        int gap;
        logic [2:0] prev;

        rst = 1'b1; req = 3'b000; data = 48'h0;
        cyc(2);
        rst = 1'b0; cmp_en = 1'b1;
        chk("rst_grant", {29'd0, grant}, 32'd0);
        chk("rst_owner", {30'd0, owner}, 32'd2);
        chk("rst_busy",  {31'd0, busy},  32'd0);
        chk("rst_bcd",   {16'd0, bcd3, bcd2, bcd1, bcd0}, 32'd0);

        // first grant and display load
        data[15:0] = 16'h1234; req = 3'b001;
        cyc(1);
        chk("first_grant", {29'd0, grant}, 32'd1);
        chk("first_owner", {30'd0, owner}, 32'd0);
        chk("first_busy",  {31'd0, busy},  32'd1);
        cyc(1);
        chk("first_bcd", {16'd0, bcd3, bcd2, bcd1, bcd0}, 32'h1234);
        req = 3'b000;
        wait_idle(20);

        // one-cycle pulse still holds the grant for the minimum dwell
        data[15:0] = 16'hABCD; req = 3'b001;
        cyc(1);
        chk("pulse_grant", {29'd0, grant}, 32'd1);
        req = 3'b000; data[15:0] = 16'h5555;
        cnt = 1;
        repeat (8) begin
            cyc(1);
            if (grant == 3'b001) cnt++;
        end
        chk("pulse_hold_cycles", cnt, 32'd4);
        chk("pulse_bcd", {16'd0, bcd3, bcd2, bcd1, bcd0}, 32'hABCD);

        // all requesting, each drops after four owned cycles
        rst = 1'b1; cyc(1); rst = 1'b0;
        data = 48'h3333_2222_1111; req = 3'b111;
        held = 0; gap = 0; prev = 3'b000;
        for (int c = 0; c < 40 && seq.size() < 4; c++) begin
            cyc(1);
            if (grant != 3'b000) begin
                if (prev == 3'b000) begin
                    seq.push_back(grant);
                    if (seq.size() > 1) gaps.push_back(gap);
                    held = 0;
                end
                held++;
                gap = 0;
            end else begin
                gap++;
            end
            prev = grant;
            req  = (grant != 3'b000 && held >= 4) ? (3'b111 & ~grant) : 3'b111;
        end
        chk("rr_grant_count", seq.size(), 32'd4);
        for (int i = 0; i < seq.size() && i < 4; i++) chk("rr_grant_order", {29'd0, seq[i]}, {29'd0, exp_seq[i]});
        for (int i = 0; i < gaps.size(); i++) chk("rr_idle_gap", gaps[i], 32'd1);
        req = 3'b000;
        wait_idle(20);

        // rival raised while owner keeps requesting
        rst = 1'b1; cyc(1); rst = 1'b0;
        data[15:0] = 16'h0F0F; req = 3'b001;
        cyc(1);
        chk("hold_grant_c1", {29'd0, grant}, 32'd1);
        cyc(1);
        req = 3'b011;
        cyc(7);
`ifdef SEG_ARB_TIMEOUT_EN
        chk("hold_grant_c9", {29'd0, grant}, 32'd0);
        cyc(1);
        chk("hold_grant_c10", {29'd0, grant}, 32'd2);
`else
        chk("hold_grant_c9", {29'd0, grant}, 32'd1);
        cyc(1);
        chk("hold_grant_c10", {29'd0, grant}, 32'd1);
`endif

        // reset in the middle of ownership
        rst = 1'b1;
        cyc(1);
        chk("midrst_grant", {29'd0, grant}, 32'd0);
        chk("midrst_bcd",   {16'd0, bcd3, bcd2, bcd1, bcd0}, 32'd0);
        chk("midrst_owner", {30'd0, owner}, 32'd2);
        chk("midrst_busy",  {31'd0, busy},  32'd0);
        rst = 1'b0; req = 3'b011;
        cyc(1);
        chk("midrst_regrant", {29'd0, grant}, 32'd1);
        req = 3'b000;
        cyc(6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/seg_arbiter.md
SEG_ARBITER -- requirements
Module: seg_arbiter

Interface
REQ-001 Parameter NREQ, default 3, number of display requesters (2..4).
REQ-002 Parameter MIN_DWELL, default 50000, minimum cycles an owner keeps the display once granted.
REQ-003 Parameter MAX_HOLD, default 2000000, cycles after which a pending rival may preempt the owner (timeout build only).
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 req  input  NREQ  per-requester display request, level.
REQ-007 data  input  16*NREQ  per-requester 4-digit value; requester i in bits [16i+15:16i], digit0 in the low nibble.
REQ-008 grant  output  NREQ  one-hot grant, registered.
REQ-009 bcd0..bcd3  output  4 each  digit values for the scan driver, registered.
REQ-010 owner  output  2  index of current or last owner.
REQ-011 busy  output  1  high while state is OWN.

Function
REQ-012 Two states: IDLE and OWN.
REQ-013 IDLE with req==0: stay IDLE; grant=0; bcd0..3 hold last value.
REQ-014 IDLE with any req bit high: round-robin pick starting at owner+1 (mod NREQ); next cycle state=OWN, grant[pick]=1, owner=pick.
REQ-015 In OWN, dwell counter starts at 0 on grant entry, increments each cycle, saturates at max(MIN_DWELL,MAX_HOLD).
REQ-016 In OWN while req[owner]=1: bcd0..3 load data[owner] each cycle (one-cycle latency from data to bcd).
REQ-017 In OWN while req[owner]=0: bcd0..3 hold last loaded value.
REQ-018 Release when req[owner]=0 and dwell >= MIN_DWELL-1: next cycle state=IDLE, grant=0.
REQ-019 A requester that drops req before MIN_DWELL keeps the grant until MIN_DWELL cycles elapse.
REQ-020 Every release passes through exactly one IDLE cycle before the next grant.
REQ-021 Simultaneous requests resolve strictly round-robin; a requester that just released has lowest priority.
REQ-022 grant is never multi-hot; grant!=0 exactly when busy=1.

Reset
REQ-023 On rst: state=IDLE, grant=0, busy=0, bcd0..3=0, dwell=0.
REQ-024 On rst, owner=NREQ-1, so requester 0 wins the first arbitration.
REQ-025 rst during OWN aborts the grant at the next edge; no display data is retained.

Configuration
REQ-026 Macro SEG_ARB_TIMEOUT_EN defined: in OWN, if dwell >= MAX_HOLD-1 and any other req bit is high, release next cycle regardless of req[owner].
REQ-027 The preempted owner then has lowest round-robin priority.
REQ-028 SEG_ARB_TIMEOUT_EN undefined: no preemption; an owner holding req keeps the display indefinitely; MAX_HOLD ignored.

Structure
REQ-029 Package seg_arb_pkg holds the state encoding, DIGIT_W=4, the per-requester width of 16, and the NREQ default.
REQ-030 One sub-module, rr_pick: combinational round-robin picker taking req and the last owner and returning pick index plus valid.

Verification
All scenarios use NREQ=3, MIN_DWELL=4, MAX_HOLD=8.
REQ-031 Reset then req=001, data0=16'h1234 -> grant=001 after 1 cycle, {bcd3..bcd0}=1,2,3,4 one cycle later, owner=0, busy=1.
REQ-032 req=111 held, each requester drops after 4 cycles of ownership -> grant sequence 001,010,100,001, with one IDLE cycle (grant=000) between grants.
REQ-033 req0 pulsed 1 cycle -> grant=001 held exactly 4 cycles, then IDLE; bcd keeps data0 sampled during the pulse.
REQ-034 Timeout build, req0 held, req1 raised at cycle 2 -> release at dwell 7, IDLE 1 cycle, grant=010. Non-timeout build, same stimulus -> grant stays 001.
REQ-035 rst asserted mid-OWN -> next cycle grant=000, bcd=0, owner=2; then req=011 -> grant=001.
